// File: rtl/reg_wr_arbiter_if.sv
// Write-port arbiter bus: two write requesters, destination reservation,
// hazard lookup and the register-bank write port.
interface reg_wr_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        mark_valid;
  logic [4:0]  mark_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hazard_rs;
  logic        hazard_rt;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        rf_wr;
  logic        busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    input  mark_valid, mark_rd, rs, rt,
    output hazard_rs, hazard_rt,
    output rf_rd, rf_data, rf_wr, busy
  );

  // Requester / environment side
  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    output mark_valid, mark_rd, rs, rt,
    input  hazard_rs, hazard_rt,
    input  rf_rd, rf_data, rf_wr, busy
  );
endinterface

// File: rtl/reg_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU writeback and
// load return, three-cycle SETUP/STROBE write sequence with a registered
// edge-triggered strobe, and a pending-write scoreboard for hazard checks.
module reg_wr_arbiter (
  input  logic             clk,
  input  logic             rst,
  reg_wr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_last_grant;   // 1: requester 1 was granted last
  logic [4:0]  r_rf_rd;
  logic [31:0] r_rf_data;
  logic        r_rf_wr;
  logic [31:0] r_pending;

  logic        w_idle;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_xfer;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  // Grant selection in IDLE plus scoreboard set/clear masks
  always_comb begin
    w_idle = (r_state == IDLE) && !rst;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_idle) begin
      w_gnt0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
      w_gnt1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
    end
    w_xfer = w_gnt0 || w_gnt1;
    w_rd   = w_gnt1 ? bus.req1_rd   : bus.req0_rd;
    w_data = w_gnt1 ? bus.req1_data : bus.req0_data;

    w_set = '0;
    if (bus.mark_valid && (bus.mark_rd != 5'd0)) w_set[bus.mark_rd] = 1'b1;
    w_clr = '0;
    if (r_state == STROBE) w_clr[r_rf_rd] = 1'b1;
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.hazard_rs  = r_pending[bus.rs];
  assign bus.hazard_rt  = r_pending[bus.rt];
  assign bus.rf_rd      = r_rf_rd;
  assign bus.rf_data    = r_rf_data;
  assign bus.rf_wr      = r_rf_wr;
  assign bus.busy       = (r_state != IDLE);

  // Write sequencer: accept in IDLE, hold address/data, pulse rf_wr in STROBE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_rf_rd      <= 5'd0;
      r_rf_data    <= 32'd0;
      r_rf_wr      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rf_wr <= 1'b0;
          if (w_xfer) begin
            r_last_grant <= w_gnt1;
            // Writes to r0 are swallowed without touching the bank
            if (w_rd != 5'd0) begin
              r_rf_rd   <= w_rd;
              r_rf_data <= w_data;
              r_state   <= SETUP;
            end
          end
        end
        SETUP: begin
          r_rf_wr <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: begin
          r_rf_wr <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_rf_wr <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Pending scoreboard: a new reservation beats a completing write to the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'd1;
    end
  end

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 SHALL have no parameters; widths fixed: 5-bit register index, 32-bit data, 32 registers.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-005 SHALL have port: req0_rd  input  5  requester 0 destination register.
REQ-006 SHALL have port: req0_data  input  32  requester 0 write data.
REQ-007 SHALL have port: req0_ready  output  1  requester 0 write accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_rd, req1_data, req1_ready with widths 1/5/32/1, same meanings for requester 1 (load return).
REQ-009 SHALL have port: mark_valid  input  1  an issuing instruction reserves a destination.
REQ-010 SHALL have port: mark_rd  input  5  register being reserved.
REQ-011 SHALL have ports: rs, rt  input  5 each  source registers to check for hazards.
REQ-012 SHALL have ports: hazard_rs, hazard_rt  output  1 each  source has a write outstanding.
REQ-013 SHALL have ports: rf_rd  output  5, rf_data  output  32, rf_wr  output  1; these drive the register bank write port, which captures on the rising edge of rf_wr.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> STROBE -> IDLE; each state lasts exactly one cycle.
REQ-016 SHALL in IDLE compute the grant combinationally: if only one valid, grant it; if both valid, grant the requester not granted last (round-robin via a last_grant flag).
REQ-017 SHALL assert reqN_ready only in IDLE and only for the granted requester; a transfer occurs when valid and ready are both high at a clock edge.
REQ-018 SHALL, on a transfer with rd != 0, register rd/data into rf_rd/rf_data, update last_grant, and enter SETUP.
REQ-019 SHALL hold rf_wr = 0 in IDLE and SETUP, and rf_wr = 1 only in STROBE (registered, glitch-free); rf_rd/rf_data stay stable from SETUP through the cycle after STROBE.
REQ-020 SHALL sustain at most one register write per 3 cycles; the next ready is asserted no earlier than the cycle after STROBE.
REQ-021 SHALL, on a transfer with rd == 0, accept it (ready high), update last_grant, remain in IDLE, and generate no rf_wr pulse.
REQ-022 SHALL keep a 32-bit pending scoreboard; on mark_valid with mark_rd != 0, set pending[mark_rd] at the clock edge.
REQ-023 SHALL clear pending[rf_rd] at the clock edge that ends STROBE.
REQ-024 SHALL let the set win when set and clear target the same register at the same edge.
REQ-025 SHALL drive hazard_rs = pending[rs] and hazard_rt = pending[rt] combinationally; pending[0] is constant 0.
REQ-026 SHALL keep requests that are valid but not granted unconsumed, with no loss and no reordering within one requester.

Reset
REQ-027 SHALL, while rst = 1, force the state to IDLE, rf_wr = 0, rf_rd = 0, rf_data = 0, pending = 0, last_grant = 1 (requester 0 wins the first tie), and both ready outputs = 0.
REQ-028 SHALL abort an in-flight write when rst asserts in SETUP or STROBE; no further rf_wr edge is produced, and operation resumes from IDLE after rst deasserts.

Verification
REQ-029 SHALL cover single write: req0 rd=5 data=0xDEADBEEF -> ready same cycle; rf_wr high exactly in the 2nd cycle after the transfer with rf_rd=5 and rf_data=0xDEADBEEF; busy for 2 cycles.
REQ-030 SHALL cover contention: req0 and req1 continuously valid (rd=1, rd=2) from reset -> grants alternate 0,1,0,1; one rf_wr pulse every 3 cycles.
REQ-031 SHALL cover r0 discard: req1 rd=0 data=0xFFFFFFFF -> ready high, no rf_wr pulse, state stays IDLE, next request accepted the following cycle.
REQ-032 SHALL cover scoreboard: mark rd=7, then rs=7 -> hazard_rs=1 until the edge ending STROBE for rd=7, then 0; mark and clear of rd=7 at the same edge -> hazard stays 1.
REQ-033 SHALL cover reset mid-write: rst pulsed during SETUP -> no rf_wr rising edge, pending all 0, the next tie granted to req0.
